// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcode constants, the fetch FSM state
// encoding and the default reset PC.
package mips_pkg;

    // Primary opcode field values (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // Fetch sequencing states
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2
    } fetch_state_t;

    // Address of the first instruction after reset
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Force an address onto a word boundary by clearing bits [1:0]
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues one instruction-memory read
// at a time, presents the returned word to the control unit and picks the
// next PC from the control unit's branch/jump decisions on consume.
//
// Hand-off to the decode side is valid/ready style: instr_valid is the
// valid, ~stall is the ready. A transfer (consume) happens on a rising edge
// where instr_valid=1 and stall=0; while stall=1 every output holds.
// branch/branch_taken/jump and both targets only matter in that consume
// cycle. Towards memory, imem_req is a one-cycle strobe and only one request
// is ever outstanding; imem_rvalid is only looked at in S_WAIT.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic         clk,
    input  logic         reset,
    // instruction memory
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic [31:0]  imem_rdata,
    input  logic         imem_rvalid,
    // downstream / control unit
    input  logic         stall,
    input  logic         branch,
    input  logic         branch_taken,
    input  logic [31:0]  branch_target,
    input  logic         jump,
    input  logic [31:0]  jump_target,
    output logic [31:0]  instr,
    output logic [5:0]   op,
    output logic [31:0]  pc,
    output logic [31:0]  pc_plus4,
    output logic         instr_valid,
    output logic [31:0]  fetch_count,
    // debug view of the FSM
    output fetch_state_t dbg_state
);

    fetch_state_t state;
    logic [31:0]  next_pc;

    // Outputs derived combinationally from registers only
    assign op        = instr[31:26];
    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;
    assign dbg_state = state;

    // Next PC on consume: jump beats a taken branch, which beats sequential.
    // The control inputs may depend on op; this path ends at the PC register.
    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = word_align(jump_target);
        end else if (branch && branch_taken) begin
            next_pc = word_align(branch_target);
        end
    end

    // Request / wait / hand-off sequencer with registered outputs.
    // After reset S_REQ first spends one cycle with imem_req=0 (the reset
    // cycle itself), then strobes; on consume the strobe is set directly so
    // the next request appears the cycle after the consume.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_REQ;
            imem_req    <= 1'b0;
            pc          <= RESET_PC;
            instr       <= 32'd0;
            instr_valid <= 1'b0;
            fetch_count <= 32'd0;
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_req) begin
                        imem_req <= 1'b0;
                        state    <= S_WAIT;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (!stall) begin
                        instr_valid <= 1'b0;
                        fetch_count <= fetch_count + 32'd1;
                        pc          <= next_pc;
                        imem_req    <= 1'b1;
                        state       <= S_REQ;
                    end
                end
                default: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    state       <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Inputs are driven and outputs sampled on the
// falling edge; the bench plays instruction memory with a chosen latency k.
module tb_fetch_unit;
    import mips_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic [31:0]  imem_rdata;
    logic         imem_rvalid;
    logic         stall;
    logic         branch;
    logic         branch_taken;
    logic [31:0]  branch_target;
    logic         jump;
    logic [31:0]  jump_target;
    logic [31:0]  instr;
    logic [5:0]   op;
    logic [31:0]  pc;
    logic [31:0]  pc_plus4;
    logic         instr_valid;
    logic [31:0]  fetch_count;
    fetch_state_t dbg_state;

    int           n_vec = 0;
    int           n_err = 0;
    logic [31:0]  exp_count = 32'd0;
    int           cyc = 0;

    // clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fetch_unit dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
        .stall(stall), .branch(branch), .branch_taken(branch_taken),
        .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
        .instr(instr), .op(op), .pc(pc), .pc_plus4(pc_plus4),
        .instr_valid(instr_valid), .fetch_count(fetch_count),
        .dbg_state(dbg_state)
    );

    task automatic step();
        @(negedge clk);
    endtask

    // Garbage on the control inputs outside consume cycles
    task automatic scramble_ctrl();
        branch        = 1'($urandom_range(0, 1));
        branch_taken  = 1'($urandom_range(0, 1));
        jump          = 1'($urandom_range(0, 1));
        branch_target = $urandom;
        jump_target   = $urandom;
    endtask

    // Wait for the request, check its address, answer with latency k,
    // then check the presented instruction.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data, input int k);
        int waited = 0;
        while (imem_req !== 1'b1 && waited < 8) begin
            step();
            waited++;
        end
        n_vec++;
        if (imem_req !== 1'b1) begin
            n_err++;
            $display("FAIL req_timeout: imem_req=%b expected 1 within 8 cycles", imem_req);
            return;
        end
        n_vec++;
        if (imem_addr !== addr) begin
            n_err++;
            $display("FAIL req_addr: got %h expected %h", imem_addr, addr);
        end
        scramble_ctrl();
        for (int i = 0; i < k; i++) step();
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        n_vec++;
        if (instr_valid !== 1'b1 || instr !== data || pc !== addr) begin
            n_err++;
            $display("FAIL fetch_data: valid=%b instr=%h pc=%h expected 1 %h %h",
                     instr_valid, instr, pc, data, addr);
        end
    endtask

    // Consume the current instruction with the given control decisions and
    // check the request that follows.
    task automatic consume(input logic j, input logic [31:0] jt, input logic br,
                           input logic tk, input logic [31:0] bt,
                           input logic [31:0] exp_next);
        jump = j; jump_target = jt;
        branch = br; branch_taken = tk; branch_target = bt;
        stall = 1'b0;
        step();
        stall = 1'b1;
        scramble_ctrl();
        exp_count = exp_count + 32'd1;
        n_vec++;
        if (imem_req !== 1'b1 || imem_addr !== exp_next) begin
            n_err++;
            $display("FAIL consume_next: req=%b addr=%h expected 1 %h", imem_req, imem_addr, exp_next);
        end
        n_vec++;
        if (fetch_count !== exp_count || instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL consume_count: count=%0d valid=%b expected %0d 0",
                     fetch_count, instr_valid, exp_count);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_vec++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || pc !== 32'h0 || pc_plus4 !== 32'h4) begin
            n_err++;
            $display("FAIL reset_pc: req=%b addr=%h pc=%h pc4=%h expected 0 0 0 4",
                     imem_req, imem_addr, pc, pc_plus4);
        end
        n_vec++;
        if (instr !== 32'h0 || op !== 6'h0 || instr_valid !== 1'b0 || fetch_count !== 32'h0
            || dbg_state !== S_REQ) begin
            n_err++;
            $display("FAIL reset_state: instr=%h op=%h valid=%b count=%0d st=%0d expected 0 0 0 0 0",
                     instr, op, instr_valid, fetch_count, dbg_state);
        end
        exp_count = 32'd0;
    endtask

    // First fetch after reset, k=1: valid arrives 3 cycles after reset drops
    task automatic test_first_fetch();
        reset = 1'b0;
        step();
        n_vec++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL first_req: req=%b addr=%h valid=%b expected 1 0 0", imem_req, imem_addr, instr_valid);
        end
        step();
        n_vec++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || dbg_state !== S_WAIT) begin
            n_err++;
            $display("FAIL first_wait: req=%b valid=%b st=%0d expected 0 0 1", imem_req, instr_valid, dbg_state);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h2008_0005;
        step();
        imem_rvalid = 1'b0;
        n_vec++;
        if (instr_valid !== 1'b1 || op !== OP_ADDI || pc !== 32'h0 || instr !== 32'h2008_0005
            || pc_plus4 !== 32'h4) begin
            n_err++;
            $display("FAIL first_valid: valid=%b op=%b pc=%h instr=%h pc4=%h expected 1 001000 0 20080005 4",
                     instr_valid, op, pc, instr, pc_plus4);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            step();
            n_vec++;
            if (instr !== 32'h2008_0005 || pc !== 32'h0 || fetch_count !== exp_count
                || imem_req !== 1'b0 || instr_valid !== 1'b1) begin
                n_err++;
                $display("FAIL stall_hold: instr=%h pc=%h count=%0d req=%b valid=%b",
                         instr, pc, fetch_count, imem_req, instr_valid);
            end
        end
        consume(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h4);
    endtask

    task automatic test_branch();
        do_fetch(32'h4, {OP_BEQ, 26'h0000010}, 1);
        consume(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0043, 32'h0000_0040);
        do_fetch(32'h40, {OP_BEQ, 26'h0000020}, 2);
        consume(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_0044);
    endtask

    task automatic test_jump_priority();
        do_fetch(32'h44, {OP_J, 26'h0000040}, 3);
        consume(1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 32'h100);
    endtask

    task automatic test_wrap_and_spurious();
        do_fetch(32'h100, {OP_J, 26'h3FFFFFF}, 1);
        consume(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC);
        do_fetch(32'hFFFF_FFFC, {OP_LW, 26'h0123456}, 2);
        n_vec++;
        if (pc_plus4 !== 32'h0) begin
            n_err++;
            $display("FAIL wrap_pc4: got %h expected 00000000", pc_plus4);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        n_vec++;
        if (instr !== {OP_LW, 26'h0123456} || dbg_state !== S_VALID || imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL spurious_rvalid: instr=%h st=%0d req=%b expected %h 2 0",
                     instr, dbg_state, imem_req, {OP_LW, 26'h0123456});
        end
        consume(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // k=1, no stall: consumes are exactly 3 cycles apart
    task automatic test_back_to_back();
        int t0;
        int t1;
        do_fetch(32'h0, {OP_RTYPE, 26'h1}, 1);
        t0 = cyc;
        consume(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h4);
        do_fetch(32'h4, {OP_SW, 26'h2}, 1);
        t1 = cyc;
        n_vec++;
        if (t1 - t0 !== 3) begin
            n_err++;
            $display("FAIL throughput: got %0d cycles expected 3", t1 - t0);
        end
        consume(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h8);
    endtask

    task automatic test_reset_in_wait();
        step();
        step();
        step();
        n_vec++;
        if (dbg_state !== S_WAIT) begin
            n_err++;
            $display("FAIL pre_reset_wait: st=%0d expected 1", dbg_state);
        end
        reset = 1'b1;
        step();
        exp_count = 32'd0;
        n_vec++;
        if (dbg_state !== S_REQ || pc !== 32'h0 || instr_valid !== 1'b0 || fetch_count !== 32'h0
            || imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL reset_in_wait: st=%0d pc=%h valid=%b count=%0d req=%b expected 0 0 0 0 0",
                     dbg_state, pc, instr_valid, fetch_count, imem_req);
        end
        reset = 1'b0;
        step();
        n_vec++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_err++;
            $display("FAIL after_reset_req: req=%b addr=%h expected 1 0", imem_req, imem_addr);
        end
        do_fetch(32'h0, 32'h2008_0005, 1);
        consume(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h4);
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        branch = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        jump = 1'b0; jump_target = 32'h0;
        test_reset();
        test_first_fetch();
        test_stall();
        test_branch();
        test_jump_priority();
        test_wrap_and_spurious();
        test_back_to_back();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
